// File: rtl/timer_pkg.sv
// Shared types and defaults for the down-counting timer.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } tmr_state_t;

    localparam int unsigned DEF_WIDTH = 8;

endpackage

// File: rtl/down_cnt_core.sv
// Counter datapath: async reset, sync clear, parallel load and decrement.
module down_cnt_core #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             dec,
    output logic [WIDTH-1:0] cnt,
    output logic             zero
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_data;
        end else if (dec && (cnt != '0)) begin
            // Guarded so the count can never wrap to all-ones.
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/down_cnt_timer.sv
// Programmable down-counting timer with one-shot / auto-reload modes and
// start/pause/clear strobes; all outputs registered.
module down_cnt_timer
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] cnt,
    output logic             busy,
    output logic             tc_pulse,
    output logic             done
);

    tmr_state_t       state_q, state_d;
    logic [WIDTH-1:0] reload_q;
    logic             core_load;
    logic [WIDTH-1:0] core_data;
    logic             core_dec;
    logic             zero;
    logic             tc_d;

    always_comb begin
        state_d   = state_q;
        core_load = 1'b0;
        core_data = load_val;
        core_dec  = 1'b0;
        tc_d      = 1'b0;
        if (clr) begin
            state_d = IDLE;
        end else if (load) begin
            state_d   = IDLE;
            core_load = 1'b1;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d   = RUN;
                        core_load = 1'b1;
                        core_data = reload_q;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_d = HOLD;
                    end else if (!zero) begin
                        core_dec = 1'b1;
                    end else begin
                        tc_d = 1'b1;
                        if (auto_reload) begin
                            core_load = 1'b1;
                            core_data = reload_q;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                HOLD: begin
                    // Resume only changes state; decrement restarts next cycle.
                    if (start) begin
                        state_d = RUN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            reload_q <= '0;
            tc_pulse <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            tc_pulse <= tc_d;
            busy     <= (state_d == RUN) || (state_d == HOLD);
            done     <= (state_d == DONE);
            if (!clr && load) begin
                reload_q <= load_val;
            end
        end
    end

    down_cnt_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (clr),
        .load     (core_load),
        .load_data(core_data),
        .dec      (core_dec),
        .cnt      (cnt),
        .zero     (zero)
    );

endmodule
